// File: rtl/alu_pkg.sv
// Shared definitions for the pipelined ARM data-processing ALU: opcode encodings,
// control-state encoding and NZCV flag bit positions.
package alu_pkg;

  localparam logic [3:0] OP_AND = 4'h0;
  localparam logic [3:0] OP_EOR = 4'h1;
  localparam logic [3:0] OP_SUB = 4'h2;
  localparam logic [3:0] OP_RSB = 4'h3;
  localparam logic [3:0] OP_ADD = 4'h4;
  localparam logic [3:0] OP_ADC = 4'h5;
  localparam logic [3:0] OP_SBC = 4'h6;
  localparam logic [3:0] OP_RSC = 4'h7;
  localparam logic [3:0] OP_TST = 4'h8;
  localparam logic [3:0] OP_TEQ = 4'h9;
  localparam logic [3:0] OP_CMP = 4'hA;
  localparam logic [3:0] OP_CMN = 4'hB;
  localparam logic [3:0] OP_ORR = 4'hC;
  localparam logic [3:0] OP_MOV = 4'hD;
  localparam logic [3:0] OP_BIC = 4'hE;
  localparam logic [3:0] OP_MVN = 4'hF;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_MUL  = 2'd1,
    ST_HOLD = 2'd2
  } state_e;

  localparam int FLAG_N = 3;
  localparam int FLAG_Z = 2;
  localparam int FLAG_C = 1;
  localparam int FLAG_V = 0;

  // Compare-class ops update flags only and never write the register file.
  function automatic logic is_compare(input logic [3:0] opcode);
    return opcode inside {OP_TST, OP_TEQ, OP_CMP, OP_CMN};
  endfunction

endpackage

// File: rtl/alu_mul_iter.sv
// Iterative shift-add multiplier: start loads a, b and an addend, done rises
// WIDTH cycles later with the low WIDTH bits of a*b + addend on product_o.
module alu_mul_iter #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start_i,
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  input  logic [WIDTH-1:0] c_i,
  output logic             done_o,
  output logic [WIDTH-1:0] product_o
);

  localparam int CW = $clog2(WIDTH + 1);

  logic             busy_q;
  logic [CW-1:0]    cnt_q;
  logic [WIDTH-1:0] mcand_q;
  logic [WIDTH-1:0] mplier_q;
  logic [WIDTH-1:0] acc_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      busy_q   <= 1'b0;
      cnt_q    <= '0;
      mcand_q  <= '0;
      mplier_q <= '0;
      acc_q    <= '0;
    end else if (start_i) begin
      busy_q   <= 1'b1;
      cnt_q    <= CW'(WIDTH);
      mcand_q  <= a_i;
      mplier_q <= b_i;
      acc_q    <= c_i;
    end else if (busy_q) begin
      if (cnt_q != '0) begin
        if (mplier_q[0]) acc_q <= acc_q + mcand_q;
        mcand_q  <= mcand_q << 1;
        mplier_q <= mplier_q >> 1;
        cnt_q    <= cnt_q - 1'b1;
      end else begin
        busy_q <= 1'b0;
      end
    end
  end

  assign done_o    = busy_q && (cnt_q == '0);
  assign product_o = acc_q;

endmodule

// File: rtl/alu_pipe.sv
// Registered ARM data-processing ALU with valid/ready handshake and internal NZCV.
// Define ALU_MUL_EN to add the iterative MUL/MLA engine and its ports.
module alu_pipe
  import alu_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [3:0]       op,
  input  logic             set_flags,
  input  logic [WIDTH-1:0] op_a,
  input  logic [WIDTH-1:0] op_b,
  input  logic             shift_carry,
`ifdef ALU_MUL_EN
  input  logic             mul_en,
  input  logic             mul_acc,
  input  logic [WIDTH-1:0] op_c,
`endif
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             result_wr,
  output logic [3:0]       nzcv
);

  state_e           state_q, state_d;
  logic [WIDTH-1:0] result_q, result_d;
  logic             wr_q, wr_d;
  logic [3:0]       nzcv_q, nzcv_d;

  logic             accept;
  logic [WIDTH-1:0] ea, eb, logic_res, dp_result;
  logic             cin, arith;
  logic [WIDTH:0]   sum;
  logic [3:0]       dp_nzcv;

  logic             mul_start, mul_done, mul_sf_q;
  logic [WIDTH-1:0] mul_product;

  // A held result blocks new work unless it is being consumed this same cycle.
  assign out_valid = (state_q == ST_HOLD);
  assign in_ready  = rst_n && (state_q != ST_MUL) && (!out_valid || out_ready);
  assign accept    = in_valid && in_ready;

  // NOTE: every variable driven here gets a default first so no latch is inferred.
  always_comb begin
    ea        = '0;
    eb        = '0;
    cin       = 1'b0;
    arith     = 1'b1;
    logic_res = '0;
    case (op)
      OP_AND, OP_TST: begin arith = 1'b0; logic_res = op_a & op_b; end
      OP_EOR, OP_TEQ: begin arith = 1'b0; logic_res = op_a ^ op_b; end
      OP_ORR:         begin arith = 1'b0; logic_res = op_a | op_b; end
      OP_MOV:         begin arith = 1'b0; logic_res = op_b; end
      OP_BIC:         begin arith = 1'b0; logic_res = op_a & ~op_b; end
      OP_MVN:         begin arith = 1'b0; logic_res = ~op_b; end
      OP_SUB, OP_CMP: begin ea = op_a; eb = ~op_b; cin = 1'b1; end
      OP_RSB:         begin ea = op_b; eb = ~op_a; cin = 1'b1; end
      OP_ADD, OP_CMN: begin ea = op_a; eb = op_b; end
      OP_ADC:         begin ea = op_a; eb = op_b;  cin = nzcv_q[FLAG_C]; end
      OP_SBC:         begin ea = op_a; eb = ~op_b; cin = nzcv_q[FLAG_C]; end
      OP_RSC:         begin ea = op_b; eb = ~op_a; cin = nzcv_q[FLAG_C]; end
      default:        begin arith = 1'b0; logic_res = '0; end
    endcase

    sum       = {1'b0, ea} + {1'b0, eb} + {{WIDTH{1'b0}}, cin};
    dp_result = arith ? sum[WIDTH-1:0] : logic_res;

    dp_nzcv = nzcv_q;
    if (set_flags) begin
      dp_nzcv[FLAG_N] = dp_result[WIDTH-1];
      dp_nzcv[FLAG_Z] = (dp_result == '0);
      if (arith) begin
        dp_nzcv[FLAG_C] = sum[WIDTH];
        dp_nzcv[FLAG_V] = (ea[WIDTH-1] == eb[WIDTH-1]) && (sum[WIDTH-1] != ea[WIDTH-1]);
      end else begin
        dp_nzcv[FLAG_C] = shift_carry;
      end
    end
  end

`ifdef ALU_MUL_EN
  assign mul_start = accept && mul_en;

  always_ff @(posedge clk) begin
    if (!rst_n)         mul_sf_q <= 1'b0;
    else if (mul_start) mul_sf_q <= set_flags;
  end

  alu_mul_iter #(.WIDTH(WIDTH)) u_mul (
    .clk       (clk),
    .rst_n     (rst_n),
    .start_i   (mul_start),
    .a_i       (op_a),
    .b_i       (op_b),
    .c_i       (mul_acc ? op_c : '0),
    .done_o    (mul_done),
    .product_o (mul_product)
  );
`else
  assign mul_start   = 1'b0;
  assign mul_done    = 1'b0;
  assign mul_sf_q    = 1'b0;
  assign mul_product = '0;
`endif

  always_comb begin
    state_d  = state_q;
    result_d = result_q;
    wr_d     = wr_q;
    nzcv_d   = nzcv_q;

    if (state_q == ST_HOLD && out_ready) state_d = ST_IDLE;

    if (accept) begin
      if (mul_start) begin
        state_d = ST_MUL;
      end else begin
        state_d  = ST_HOLD;
        result_d = dp_result;
        wr_d     = !is_compare(op);
        nzcv_d   = dp_nzcv;
      end
    end

    // Multiply results touch N and Z only; C and V keep their previous values.
    if (state_q == ST_MUL && mul_done) begin
      state_d  = ST_HOLD;
      result_d = mul_product;
      wr_d     = 1'b1;
      if (mul_sf_q) begin
        nzcv_d[FLAG_N] = mul_product[WIDTH-1];
        nzcv_d[FLAG_Z] = (mul_product == '0);
      end
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= ST_IDLE;
      result_q <= '0;
      wr_q     <= 1'b0;
      nzcv_q   <= 4'b0000;
    end else begin
      state_q  <= state_d;
      result_q <= result_d;
      wr_q     <= wr_d;
      nzcv_q   <= nzcv_d;
    end
  end

  assign result    = result_q;
  assign result_wr = wr_q;
  assign nzcv      = nzcv_q;

endmodule

// File: tb/tb_alu_pipe.sv
// Self-checking bench for alu_pipe: directed scenarios plus a randomized stream
// scored against an arithmetic reference model; MUL cases run when ALU_MUL_EN is set.
module tb_alu_pipe;
  import alu_pkg::*;

  localparam int W = 32;

  logic          clk = 1'b0;
  logic          rst_n, in_valid, in_ready, set_flags, shift_carry;
  logic          out_valid, out_ready, result_wr;
  logic [3:0]    op, nzcv;
  logic [W-1:0]  op_a, op_b, result;
`ifdef ALU_MUL_EN
  logic          mul_en, mul_acc;
  logic [W-1:0]  op_c;
`endif

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  alu_pipe #(.WIDTH(W)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .op          (op),
    .set_flags   (set_flags),
    .op_a        (op_a),
    .op_b        (op_b),
    .shift_carry (shift_carry),
`ifdef ALU_MUL_EN
    .mul_en      (mul_en),
    .mul_acc     (mul_acc),
    .op_c        (op_c),
`endif
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .result      (result),
    .result_wr   (result_wr),
    .nzcv        (nzcv)
  );

  // Reference model: true unsigned/signed arithmetic in 64 bits.
  function automatic void model(input logic [3:0] o, input logic [W-1:0] a, input logic [W-1:0] b,
                                input logic sc, input logic sf, input logic [3:0] fin,
                                output logic [W-1:0] r, output logic wr, output logic [3:0] fout);
    longint ua = longint'(a);
    longint ub = longint'(b);
    longint sa = longint'($signed(a));
    longint sb = longint'($signed(b));
    longint cl = longint'(fin[1]);
    longint ur = 0;
    longint sr = 0;
    bit     arith = 1'b1;
    bit     sub = 1'b0;
    bit     c = 1'b0;
    bit     v = 1'b0;
    r = '0;
    case (o)
      OP_AND, OP_TST: begin arith = 1'b0; r = a & b; end
      OP_EOR, OP_TEQ: begin arith = 1'b0; r = a ^ b; end
      OP_ORR:         begin arith = 1'b0; r = a | b; end
      OP_MOV:         begin arith = 1'b0; r = b; end
      OP_BIC:         begin arith = 1'b0; r = a & ~b; end
      OP_MVN:         begin arith = 1'b0; r = ~b; end
      OP_ADD, OP_CMN: begin ur = ua + ub;      sr = sa + sb; end
      OP_ADC:         begin ur = ua + ub + cl; sr = sa + sb + cl; end
      OP_SUB, OP_CMP: begin ur = ua - ub;            sr = sa - sb;            sub = 1'b1; end
      OP_SBC:         begin ur = ua - ub - (1 - cl); sr = sa - sb - (1 - cl); sub = 1'b1; end
      OP_RSB:         begin ur = ub - ua;            sr = sb - sa;            sub = 1'b1; end
      default:        begin ur = ub - ua - (1 - cl); sr = sb - sa - (1 - cl); sub = 1'b1; end
    endcase
    if (arith) begin
      r = ur[W-1:0];
      c = sub ? (ur >= 0) : (ur >= (longint'(1) << W));
      v = (sr > ((longint'(1) << (W - 1)) - 1)) || (sr < -(longint'(1) << (W - 1)));
    end
    wr = !(o inside {OP_TST, OP_TEQ, OP_CMP, OP_CMN});
    fout = fin;
    if (sf) begin
      fout[3] = r[W-1];
      fout[2] = (r == '0);
      fout[1] = arith ? c : sc;
      if (arith) fout[0] = v;
    end
  endfunction

  function automatic logic [W-1:0] pick();
    case ($urandom_range(0, 5))
      0:       return 32'h0000_0000;
      1:       return 32'h0000_0001;
      2:       return 32'h7FFF_FFFF;
      3:       return 32'h8000_0000;
      4:       return 32'hFFFF_FFFF;
      default: return $urandom;
    endcase
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [3:0] o, input logic [W-1:0] a, input logic [W-1:0] b,
                       input logic sc, input logic sf);
    in_valid = 1'b1; op = o; op_a = a; op_b = b; shift_carry = sc; set_flags = sf;
  endtask

  // Present one op, wait (bounded) for in_ready, and step past the accepting edge.
  task automatic send(input logic [3:0] o, input logic [W-1:0] a, input logic [W-1:0] b,
                      input logic sc, input logic sf);
    int n = 0;
    drive(o, a, b, sc, sf);
    #1;
    while (!in_ready && n < 100) begin tick(); #1; n++; end
    checks++;
    if (in_ready !== 1'b1) begin
      errors++;
      $display("FAIL accept_timeout: in_ready=%b after %0d cycles, required 1", in_ready, n);
    end
    tick();
    in_valid = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    op = OP_AND; op_a = '0; op_b = '0; shift_carry = 1'b0; set_flags = 1'b0;
`ifdef ALU_MUL_EN
    mul_en = 1'b0; mul_acc = 1'b0; op_c = '0;
`endif
    tick(); tick();
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid: got %b, required 0", out_valid); end
    checks++; if (result !== '0) begin errors++; $display("FAIL reset_result: got %h, required 0", result); end
    checks++; if (result_wr !== 1'b0) begin errors++; $display("FAIL reset_result_wr: got %b, required 0", result_wr); end
    checks++; if (nzcv !== 4'b0000) begin errors++; $display("FAIL reset_nzcv: got %b, required 0000", nzcv); end
    checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL reset_in_ready: got %b, required 0", in_ready); end
    rst_n = 1'b1;
    #1;
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL post_reset_in_ready: got %b, required 1", in_ready); end
  endtask

  task automatic test_add_overflow();
    out_ready = 1'b1;
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL add_pre_valid: got %b, required 0", out_valid); end
    send(OP_ADD, 32'h7FFF_FFFF, 32'h1, 1'b0, 1'b1);
    checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL add_latency: out_valid=%b, required 1", out_valid); end
    checks++; if (result !== 32'h8000_0000) begin errors++; $display("FAIL add_result: got %h, required 80000000", result); end
    checks++; if (nzcv !== 4'b1001) begin errors++; $display("FAIL add_nzcv: got %b, required 1001", nzcv); end
    checks++; if (result_wr !== 1'b1) begin errors++; $display("FAIL add_wr: got %b, required 1", result_wr); end
    tick();
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL add_valid_drop: got %b, required 0", out_valid); end
  endtask

  task automatic test_cmp_carry_chain();
    out_ready = 1'b1;
    send(OP_CMP, 32'd3, 32'd5, 1'b0, 1'b1);
    checks++; if (result_wr !== 1'b0) begin errors++; $display("FAIL cmp_wr: got %b, required 0", result_wr); end
    checks++; if (nzcv !== 4'b1000) begin errors++; $display("FAIL cmp_nzcv: got %b, required 1000", nzcv); end
    send(OP_ADC, 32'd1, 32'd1, 1'b0, 1'b0);
    checks++; if (result !== 32'd2) begin errors++; $display("FAIL adc_result: got %h, required 2", result); end
    checks++; if (nzcv !== 4'b1000) begin errors++; $display("FAIL adc_keeps_flags: got %b, required 1000", nzcv); end
    send(OP_SUB, 32'd5, 32'd5, 1'b0, 1'b1);
    checks++; if (nzcv !== 4'b0110) begin errors++; $display("FAIL sub_nzcv: got %b, required 0110", nzcv); end
    send(OP_SBC, 32'd10, 32'd3, 1'b0, 1'b0);
    checks++; if (result !== 32'd7) begin errors++; $display("FAIL sbc_result: got %h, required 7", result); end
    tick();
  endtask

  task automatic test_logical_flags();
    out_ready = 1'b1;
    send(OP_ADD, 32'h7FFF_FFFF, 32'h1, 1'b0, 1'b1);
    send(OP_MOV, $urandom, 32'h0, 1'b1, 1'b1);
    checks++; if (result !== 32'h0) begin errors++; $display("FAIL mov_result: got %h, required 0", result); end
    checks++; if (nzcv !== 4'b0111) begin errors++; $display("FAIL mov_nzcv: got %b, required 0111", nzcv); end
    tick();
  endtask

  task automatic test_stall();
    out_ready = 1'b0;
    send(OP_ADD, 32'd2, 32'd3, 1'b0, 1'b1);
    drive(OP_ADD, 32'd7, 32'd8, 1'b0, 1'b1);
    for (int i = 0; i < 3; i++) begin
      #1;
      checks++;
      if (in_ready !== 1'b0 || out_valid !== 1'b1 || result !== 32'd5 || nzcv !== 4'b0000) begin
        errors++;
        $display("FAIL stall_hold[%0d]: in_ready=%b out_valid=%b result=%h nzcv=%b, required 0 1 5 0000",
                 i, in_ready, out_valid, result, nzcv);
      end
      tick();
    end
    out_ready = 1'b1;
    #1;
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL stall_release_ready: got %b, required 1", in_ready); end
    tick();
    in_valid = 1'b0;
    checks++; if (out_valid !== 1'b1 || result !== 32'd15) begin
      errors++; $display("FAIL stall_next_result: out_valid=%b result=%h, required 1 f", out_valid, result);
    end
    tick();
  endtask

  task automatic test_back_to_back();
    logic [W-1:0] a, b;
    out_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      a = $urandom; b = $urandom;
      drive(OP_ADD, a, b, 1'b0, 1'b0);
      #1;
      checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL b2b_ready[%0d]: got %b, required 1", i, in_ready); end
      tick();
      checks++;
      if (out_valid !== 1'b1 || result !== a + b) begin
        errors++; $display("FAIL b2b_result[%0d]: out_valid=%b result=%h, required 1 %h", i, out_valid, result, a + b);
      end
    end
    in_valid = 1'b0;
    tick();
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL b2b_drain: out_valid=%b, required 0", out_valid); end
  endtask

  task automatic test_random();
    logic [W+4:0] q[$];
    logic [W+4:0] e;
    logic [W-1:0] r;
    logic         wr;
    logic [3:0]   nf, fo;
    logic         exp_ready;
    rst_n = 1'b0; in_valid = 1'b0;
    tick();
    rst_n = 1'b1;
    nf = 4'b0000;
    for (int cyc = 0; cyc < 420; cyc++) begin
      if (cyc < 400) begin
        in_valid = ($urandom_range(0, 9) < 7);
        drive($urandom_range(0, 15), pick(), pick(), $urandom_range(0, 1), $urandom_range(0, 1));
        in_valid = ($urandom_range(0, 9) < 7);
        out_ready = ($urandom_range(0, 9) < 7);
      end else begin
        in_valid = 1'b0;
        out_ready = 1'b1;
      end
      #1;
      exp_ready = (q.size() == 0) || out_ready;
      checks++; if (in_ready !== exp_ready) begin errors++; $display("FAIL rnd_in_ready@%0d: got %b, required %b", cyc, in_ready, exp_ready); end
      checks++; if (out_valid !== (q.size() != 0)) begin errors++; $display("FAIL rnd_out_valid@%0d: got %b, required %b", cyc, out_valid, q.size() != 0); end
      if (out_valid && out_ready && q.size() > 0) begin
        e = q.pop_front();
        checks++;
        if ({result, result_wr, nzcv} !== e) begin
          errors++;
          $display("FAIL rnd_result@%0d: got r=%h wr=%b nzcv=%b, required r=%h wr=%b nzcv=%b",
                   cyc, result, result_wr, nzcv, e[W+4:5], e[4], e[3:0]);
        end
      end
      if (in_valid && in_ready) begin
        model(op, op_a, op_b, shift_carry, set_flags, nf, r, wr, fo);
        q.push_back({r, wr, fo});
        nf = fo;
      end
      tick();
    end
    in_valid = 1'b0;
  endtask

`ifdef ALU_MUL_EN
  task automatic test_mul();
    int n;
    logic [W-1:0] a, b, c;
    out_ready = 1'b1;
    send(OP_ADD, 32'hFFFF_FFFF, 32'h1, 1'b0, 1'b1);
    checks++; if (nzcv !== 4'b0110) begin errors++; $display("FAIL mul_setup_nzcv: got %b, required 0110", nzcv); end
    tick();
    mul_en = 1'b1; mul_acc = 1'b0;
    send(OP_ADD, 32'h0000_FFFF, 32'h0001_0001, 1'b0, 1'b1);
    mul_en = 1'b0;
    checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL mul_busy_ready: got %b, required 0", in_ready); end
    n = 0;
    while (!out_valid && n < 100) begin tick(); n++; end
    checks++; if (n != W + 1) begin errors++; $display("FAIL mul_latency: got %0d cycles, required %0d", n, W + 1); end
    checks++; if (result !== 32'hFFFF_FFFF) begin errors++; $display("FAIL mul_result: got %h, required ffffffff", result); end
    checks++; if (nzcv !== 4'b1010) begin errors++; $display("FAIL mul_nzcv: got %b, required 1010", nzcv); end
    tick();
    a = $urandom; b = $urandom; c = $urandom;
    mul_en = 1'b1; mul_acc = 1'b1; op_c = c;
    send(OP_ADD, a, b, 1'b0, 1'b0);
    mul_en = 1'b0; mul_acc = 1'b0;
    n = 0;
    while (!out_valid && n < 100) begin tick(); n++; end
    checks++; if (result !== a * b + c) begin errors++; $display("FAIL mla_result: got %h, required %h", result, a * b + c); end
    tick();
  endtask

  task automatic test_mul_reset();
    bit seen = 1'b0;
    out_ready = 1'b1;
    mul_en = 1'b1;
    send(OP_ADD, 32'h0000_FFFF, 32'h0001_0001, 1'b0, 1'b1);
    mul_en = 1'b0;
    repeat (9) tick();
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    for (int i = 0; i < 40; i++) begin
      if (out_valid === 1'b1) seen = 1'b1;
      tick();
    end
    checks++; if (seen) begin errors++; $display("FAIL mul_reset_valid: out_valid rose after reset, required never"); end
    checks++; if (nzcv !== 4'b0000) begin errors++; $display("FAIL mul_reset_nzcv: got %b, required 0000", nzcv); end
  endtask
`endif

  initial begin
    test_reset();
    test_add_overflow();
    test_cmp_carry_chain();
    test_logical_flags();
    test_stall();
    test_back_to_back();
    test_random();
`ifdef ALU_MUL_EN
    test_mul();
    test_mul_reset();
`endif
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
